// File: rtl/alu_issue_queue.sv
// alu_issue_queue: buffers tagged ALU commands, issues them into the
// two-stage ALU pipeline under credit control and re-tags the results.

package common;
  typedef enum logic [1:0] {
    nop = 2'd0,
    add = 2'd1,
    sub = 2'd2
  } operation_t;
endpackage

module alu_issue_queue
  import common::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned RSP_DEPTH = 8,
  parameter int unsigned TAG_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  operation_t       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output operation_t       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_valid,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_out_valid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic             err
);

  localparam int unsigned CMD_AW = $clog2(CMD_DEPTH);
  localparam int unsigned CMD_CW = CMD_AW + 1;
  localparam int unsigned RSP_AW = $clog2(RSP_DEPTH);
  localparam int unsigned CNT_W  = RSP_AW + 1;
  localparam int unsigned SUM_W  = CNT_W + 1;

  typedef struct packed {
    operation_t       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  // Command FIFO state
  cmd_t              cmd_mem_q [CMD_DEPTH];
  logic [CMD_AW-1:0] cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  logic [CMD_CW-1:0] cmd_cnt_q, cmd_cnt_d;
  logic              cmd_push, cmd_pop, cmd_empty, cmd_full, ready_q;
  cmd_t              cmd_in, cmd_head;

  // Tag FIFO state
  logic [TAG_W-1:0]  tag_mem_q [RSP_DEPTH];
  logic [RSP_AW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CNT_W-1:0]  tag_cnt_q, tag_cnt_d;
  logic              tag_empty;

  // Response FIFO state
  rsp_t              rsp_mem_q [RSP_DEPTH];
  logic [RSP_AW-1:0] rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [CNT_W-1:0]  rsp_cnt_q, rsp_cnt_d;
  logic              rsp_push, rsp_pop, rsp_empty;
  rsp_t              rsp_in, rsp_head;

  // Issue/credit state and registered ALU drive
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [SUM_W-1:0]  credit_sum;
  logic              issue;
  operation_t        alu_op_q, alu_op_d;
  logic [WIDTH-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic              alu_valid_q, alu_valid_d, err_q, err_d;

  assign cmd_in    = '{op: cmd_op, a: cmd_a, b: cmd_b, tag: cmd_tag};
  assign cmd_head  = cmd_mem_q[cmd_rd_q];
  assign cmd_empty = (cmd_cnt_q == '0);
  assign cmd_full  = (cmd_cnt_q == CMD_CW'(CMD_DEPTH));
  assign cmd_ready = ready_q && !cmd_full;
  assign cmd_push  = cmd_valid && cmd_ready;

  // Credit: a slot is reserved in the response FIFO for every issued command
  assign credit_sum = SUM_W'(inflight_q) + SUM_W'(rsp_cnt_q);
  assign issue      = !cmd_empty && (credit_sum < SUM_W'(RSP_DEPTH));
  assign cmd_pop    = issue;

  assign tag_empty = (tag_cnt_q == '0);
  assign rsp_push  = alu_out_valid && !tag_empty;
  assign rsp_in    = '{data: alu_out, tag: tag_mem_q[tag_rd_q]};
  assign rsp_head  = rsp_mem_q[rsp_rd_q];
  assign rsp_empty = (rsp_cnt_q == '0);
  assign rsp_valid = !rsp_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_empty ? '0 : rsp_head.data;
  assign rsp_tag   = rsp_empty ? '0 : rsp_head.tag;

  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_valid = alu_valid_q;
  assign err       = err_q;
  assign busy      = !cmd_empty || !rsp_empty || (inflight_q != '0);

  // Next-state for pointers, counters, ALU drive and error flag
  always_comb begin
    cmd_wr_d    = cmd_push ? cmd_wr_q + CMD_AW'(1) : cmd_wr_q;
    cmd_rd_d    = cmd_pop ? cmd_rd_q + CMD_AW'(1) : cmd_rd_q;
    cmd_cnt_d   = cmd_cnt_q + CMD_CW'(cmd_push) - CMD_CW'(cmd_pop);
    tag_wr_d    = issue ? tag_wr_q + RSP_AW'(1) : tag_wr_q;
    tag_rd_d    = rsp_push ? tag_rd_q + RSP_AW'(1) : tag_rd_q;
    tag_cnt_d   = tag_cnt_q + CNT_W'(issue) - CNT_W'(rsp_push);
    rsp_wr_d    = rsp_push ? rsp_wr_q + RSP_AW'(1) : rsp_wr_q;
    rsp_rd_d    = rsp_pop ? rsp_rd_q + RSP_AW'(1) : rsp_rd_q;
    rsp_cnt_d   = rsp_cnt_q + CNT_W'(rsp_push) - CNT_W'(rsp_pop);
    inflight_d  = inflight_q + CNT_W'(issue) - CNT_W'(rsp_push);
    alu_valid_d = issue;
    alu_op_d    = issue ? cmd_head.op : nop;
    alu_a_d     = issue ? cmd_head.a : '0;
    alu_b_d     = issue ? cmd_head.b : '0;
    err_d       = err_q || (alu_out_valid && tag_empty);
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q     <= 1'b0;
      cmd_wr_q    <= '0;
      cmd_rd_q    <= '0;
      cmd_cnt_q   <= '0;
      tag_wr_q    <= '0;
      tag_rd_q    <= '0;
      tag_cnt_q   <= '0;
      rsp_wr_q    <= '0;
      rsp_rd_q    <= '0;
      rsp_cnt_q   <= '0;
      inflight_q  <= '0;
      alu_valid_q <= 1'b0;
      alu_op_q    <= nop;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      ready_q     <= 1'b1;
      cmd_wr_q    <= cmd_wr_d;
      cmd_rd_q    <= cmd_rd_d;
      cmd_cnt_q   <= cmd_cnt_d;
      tag_wr_q    <= tag_wr_d;
      tag_rd_q    <= tag_rd_d;
      tag_cnt_q   <= tag_cnt_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_cnt_q   <= rsp_cnt_d;
      inflight_q  <= inflight_d;
      alu_valid_q <= alu_valid_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      err_q       <= err_d;
    end
  end

  // FIFO storage; contents are only observed through the counters
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem_q[cmd_wr_q] <= cmd_in;
    if (issue)    tag_mem_q[tag_wr_q] <= cmd_head.tag;
    if (rsp_push) rsp_mem_q[rsp_wr_q] <= rsp_in;
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue with a behavioural two-stage ALU.

module tb_alu_issue_queue;
  import common::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  operation_t  cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic [3:0]  cmd_tag;
  operation_t  alu_op;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_valid, alu_out_valid;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        busy, err;
  logic        spur;

  int errors = 0;
  int checks = 0;
  int issue_cnt = 0;
  int av_run = 0;
  int av_max = 0;
  int stall_cnt = 0;
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  alu_issue_queue #(.WIDTH(32), .CMD_DEPTH(4), .RSP_DEPTH(8), .TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_valid(alu_valid),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .busy(busy), .err(err)
  );

  // Behavioural ALU: result computed in stage 1, presented from stage 2
  logic        s1_v, s2_v;
  logic [31:0] s1_r, s2_r;

  function automatic logic [31:0] alu_f(input operation_t op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      add:     return a + b;
      sub:     return a - b;
      default: return 32'd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v <= 1'b0; s2_v <= 1'b0; s1_r <= '0; s2_r <= '0;
    end else begin
      s1_v <= alu_valid;
      s1_r <= alu_f(alu_op, alu_a, alu_b);
      s2_v <= s1_v;
      s2_r <= s1_r;
    end
  end

  assign alu_out       = s2_r;
  assign alu_out_valid = s2_v || spur;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one command; returns at the negedge after it was accepted
  task automatic send(input operation_t op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input logic [31:0] exp);
    int  n;
    logic got;
    n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    got = 1'b0;
    while (!got && n < 200) begin
      got = cmd_ready;
      if (got) exp_q.push_back({exp, tag});
      else n++;
      @(negedge clk);
    end
    stall_cnt += n;
    if (!got) begin
      errors++; checks++;
      $display("FAIL send_timeout: tag %0d not accepted within 200 cycles", tag);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      errors++; checks++;
      $display("FAIL drain_timeout: busy=%0d pending=%0d expected idle", busy, exp_q.size());
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 0);
    chk({tag, "_alu_valid"}, 64'(alu_valid), 0);
    chk({tag, "_alu_op"},    64'(alu_op), 64'(nop));
    chk({tag, "_alu_a"},     64'(alu_a), 0);
    chk({tag, "_alu_b"},     64'(alu_b), 0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
    chk({tag, "_rsp_data"},  64'(rsp_data), 0);
    chk({tag, "_rsp_tag"},   64'(rsp_tag), 0);
    chk({tag, "_busy"},      64'(busy), 0);
    chk({tag, "_err"},       64'(err), 0);
  endtask

  // Monitor: checks the response head against the scoreboard, counts issues
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        av_run = 0;
      end else begin
        if (alu_valid) begin
          issue_cnt++;
          av_run++;
          if (av_run > av_max) av_max = av_run;
        end else begin
          av_run = 0;
        end
        if (rsp_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: data=%0h tag=%0d with none pending", rsp_data, rsp_tag);
          end else begin
            if ({rsp_data, rsp_tag} !== exp_q[0]) begin
              errors++;
              $display("FAIL rsp_head: data=%0h tag=%0d expected data=%0h tag=%0d",
                       rsp_data, rsp_tag, exp_q[0][35:4], exp_q[0][3:0]);
            end
            if (rsp_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = nop; cmd_a = '0; cmd_b = '0;
    cmd_tag = '0; rsp_ready = 1'b1; spur = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(cmd_ready), 1);

    // Single add with latency checks
    send(add, 32'd5, 32'd7, 4'd3, 32'd12);
    chk("lat_k0_alu_valid", 64'(alu_valid), 0);
    @(negedge clk);
    chk("lat_k1_alu_valid", 64'(alu_valid), 1);
    chk("lat_k1_alu_op", 64'(alu_op), 64'(add));
    chk("lat_k1_alu_a", 64'(alu_a), 5);
    chk("lat_k1_alu_b", 64'(alu_b), 7);
    @(negedge clk);
    chk("lat_k2_alu_valid", 64'(alu_valid), 0);
    @(negedge clk);
    chk("lat_k3_rsp_valid", 64'(rsp_valid), 0);
    @(negedge clk);
    chk("lat_k4_rsp_valid", 64'(rsp_valid), 1);
    chk("lat_k4_rsp_data", 64'(rsp_data), 12);
    chk("lat_k4_rsp_tag", 64'(rsp_tag), 3);
    wait_idle();
    chk("single_busy_idle", 64'(busy), 0);

    // Subtract wrap-around and nop
    send(sub, 32'd0, 32'd1, 4'd9, 32'hFFFF_FFFF);
    send(nop, 32'd4, 32'd4, 4'd5, 32'd0);
    wait_idle();

    // Streaming 20 back-to-back commands
    av_max = 0; issue_cnt = 0; stall_cnt = 0;
    for (int i = 0; i < 20; i++)
      send(add, 32'h1000_0000 + 32'(i), 32'(i) * 32'd7, 4'(i % 16), 32'h1000_0000 + 32'(i) * 32'd8);
    wait_idle();
    chk("stream_stalls", 64'(stall_cnt), 0);
    chk("stream_alu_valid_run", 64'(av_max), 20);
    chk("stream_issue_cnt", 64'(issue_cnt), 20);

    // Backpressure: 8 credits issue, 4 more fill the command FIFO
    rsp_ready = 1'b0; issue_cnt = 0;
    for (int i = 0; i < 12; i++)
      send((i % 2 == 0) ? add : sub, 32'd200 + 32'(i), 32'(i), 4'(i),
           (i % 2 == 0) ? 32'd200 + 32'(2 * i) : 32'd200);
    repeat (8) @(negedge clk);
    chk("bp_issue_cnt", 64'(issue_cnt), 8);
    chk("bp_cmd_ready", 64'(cmd_ready), 0);
    chk("bp_rsp_valid", 64'(rsp_valid), 1);
    chk("bp_busy", 64'(busy), 1);
    rsp_ready = 1'b1;
    for (int i = 12; i < 16; i++)
      send((i % 2 == 0) ? add : sub, 32'd200 + 32'(i), 32'(i), 4'(i),
           (i % 2 == 0) ? 32'd200 + 32'(2 * i) : 32'd200);
    wait_idle();
    chk("bp_issue_total", 64'(issue_cnt), 16);
    chk("bp_err", 64'(err), 0);

    // Reset with work in flight and buffered
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(add, 32'(i), 32'd1000, 4'(10 + i), 32'd1000 + 32'(i));
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_no_stale", 64'(rsp_valid), 0);
    chk("midrst_idle", 64'(busy), 0);
    send(add, 32'hDEAD_0000, 32'h0000_BEEF, 4'd6, 32'hDEAD_BEEF);
    wait_idle();

    // Spurious return with the tag FIFO empty
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk("spur_err_set", 64'(err), 1);
    repeat (3) @(negedge clk);
    chk("spur_err_held", 64'(err), 1);
    chk("spur_no_rsp", 64'(rsp_valid), 0);
    chk("spur_busy", 64'(busy), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("spur_err_cleared", 64'(err), 0);
    reset = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Command front end for the `alu` execution stage. It accepts tagged ALU commands over a valid/ready interface and buffers them in a command FIFO. It issues one command per cycle into the ALU's unstallable two-register pipeline, then pairs each returning result with its tag and presents it on a backpressured response interface. Credit accounting guarantees that no ALU result is ever dropped.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; must equal the ALU's `WIDTH`.
- `CMD_DEPTH`, 4, command FIFO entries (power of 2, ≥2).
- `RSP_DEPTH`, 8, response FIFO entries and tag FIFO entries (power of 2, ≥4).
- `TAG_W`, 4, command tag width.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_op`  in  `common::operation_t`  operation (add/sub/nop).
- `cmd_a`, `cmd_b`  in  WIDTH  operands.
- `cmd_tag`  in  TAG_W  opaque tag returned with the result.
- `alu_op`  out  `common::operation_t`  to ALU `op_in`.
- `alu_a`, `alu_b`  out  WIDTH  to ALU `a_in`/`b_in`.
- `alu_valid`  out  1  to ALU `in_valid`.
- `alu_out`  in  WIDTH  from ALU `out`.
- `alu_out_valid`  in  1  from ALU `out_valid`.
- `rsp_valid`  out  1  response FIFO not empty.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_data`  out  WIDTH  result at response head.
- `rsp_tag`  out  TAG_W  tag at response head.
- `busy`  out  1  any FIFO non-empty or `inflight`≠0.
- `err`  out  1  sticky: `alu_out_valid` seen while tag FIFO empty.

## Operation
- Command FIFO: push on `cmd_valid && cmd_ready`, with `cmd_ready = !cmd_full`. A push attempt while full is not accepted and its data is ignored. Pop happens on issue. Push and pop in the same cycle are allowed at any occupancy; at full, ready is low, so only the pop happens.
- `inflight` counter, range 0..RSP_DEPTH: +1 on issue, −1 on response-FIFO push; both in the same cycle leaves it unchanged.
- Issue condition, evaluated per cycle: `!cmd_empty && (inflight + rsp_count) < RSP_DEPTH`. A response pop in the same cycle does not add credit until the next cycle.
- On issue, registered at the edge: `alu_op/alu_a/alu_b` ← FIFO head, `alu_valid` ← 1, and `cmd_tag` of the head is pushed into the tag FIFO.
- No-issue cycle: `alu_valid` ← 0, `alu_op` ← `common::nop`, `alu_a`/`alu_b` ← 0.
- Return path, on `alu_out_valid`:
  - pop the tag FIFO;
  - push {`alu_out`, popped tag} into the response FIFO at the edge.
  - If the tag FIFO is empty: set `err`, push nothing.
- Credits guarantee the response FIFO is never full when a push is required.
- Response FIFO: `rsp_valid = !rsp_empty`; pop on `rsp_valid && rsp_ready`. Push and pop in the same cycle are allowed.
- Results return in issue order; the ALU pipeline is in-order.
- `cmd_op = nop` issues normally and returns data 0 with its tag.
- Reset asserted mid-operation clears all FIFOs, `inflight`, and `err`. The ALU shares the reset, so in-flight operations are discarded and no stale `alu_out_valid` appears.

## Timing
- Reset values:
  - `cmd_ready`=0 while reset is asserted, 1 in the first cycle after deassertion;
  - `alu_valid`=0, `alu_op`=nop, `alu_a`=`alu_b`=0;
  - `rsp_valid`=0, `rsp_data`=0, `rsp_tag`=0, `busy`=0, `err`=0.
- Latency with the command accepted at edge k, empty design, `rsp_ready`=1:
  - issue at edge k+1 (`alu_valid` high during k+1..k+2);
  - ALU registers at k+2, `alu_out_valid` at k+3;
  - response push at k+4, `rsp_valid` high after edge k+4.
  - Total: 4 cycles.
- Throughput: one command per cycle sustained with `RSP_DEPTH`≥8 and `rsp_ready` held high.
- `rsp_data`/`rsp_tag` are stable while `rsp_valid && !rsp_ready`.
- `cmd_ready`, `rsp_valid`, and `busy` are derived from registered state only; none depends combinationally on `cmd_valid` or `rsp_ready`.

## Test plan
- Single add: a=5, b=7, tag=3 accepted at edge k → `alu_valid` after k+1 with op=add; `rsp_valid` after edge k+4 with data=12, tag=3; `busy` returns to 0.
- Sub wrap-around: a=0, b=1, tag=9 → `rsp_data`=0xFFFFFFFF, tag=9. Also nop with a=4, b=4 → data=0.
- Streaming: 20 back-to-back commands, tags 0..15 then 0..3, `rsp_ready`=1:
  - `cmd_ready` never drops;
  - `alu_valid` is continuous for 20 cycles;
  - responses arrive in order with exact sums.
- Backpressure/credit: hold `rsp_ready`=0 and offer 16 commands.
  - Exactly 8 issue, `inflight`+`rsp_count`≤8 at all times, and the 4 following commands fill the command FIFO (`cmd_ready`=0).
  - After `rsp_ready` is released, all 16 drain in order with no loss and `err`=0.
- Reset mid-stream: assert reset with 3 in flight and 2 buffered → all outputs reach reset values; after release, one new command returns correctly and no stale response appears.
- Spurious return: force `alu_out_valid`=1 with the tag FIFO empty → `err`=1 and held, no response pushed.
